// File: rtl/id_stage_pkg.sv
// Shared types for the RV32I decode stage: widths, opcodes, check_regs codes,
// the ID/EX payload and immediate-extraction helpers.
// The optional ID_STALL_COUNT_EN macro adds a saturating stall-cycle counter.
package id_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ALEN = 5;
    localparam int unsigned CHKW = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [CHKW-1:0] {
        CHK_NONE    = 2'b00,
        CHK_RS1     = 2'b01,
        CHK_RS2     = 2'b10,
        CHK_RS1_RS2 = 2'b11
    } check_regs_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [ALEN-1:0] rd;
        logic [ALEN-1:0] rs1;
        logic [ALEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [XLEN-1:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch / stall-controller / EXE signal bundle for the decode stage.
// o_stall_cycles exists only when ID_STALL_COUNT_EN is defined.
interface id_stage_if;
    import id_stage_pkg::*;

    logic            i_if_valid;
    logic [XLEN-1:0] i_if_pc;
    logic [XLEN-1:0] i_if_instr;
    logic            o_if_ready;
    logic            i_flush;
    logic            i_stall;
    logic [ALEN-1:0] o_rs1;
    logic [ALEN-1:0] o_rs2;
    logic [CHKW-1:0] o_check_regs;
    logic            o_is_valid;
    logic            o_pipeline_stalled;
    logic            o_ex_valid;
    logic [XLEN-1:0] o_ex_pc;
    logic [XLEN-1:0] o_ex_instr;
    logic [ALEN-1:0] o_ex_rd;
    logic [ALEN-1:0] o_ex_rs1;
    logic [ALEN-1:0] o_ex_rs2;
    logic [XLEN-1:0] o_ex_imm;
`ifdef ID_STALL_COUNT_EN
    logic [31:0]     o_stall_cycles;
`endif

    // Decode stage side
    modport slave (
        input  i_if_valid, i_if_pc, i_if_instr, i_flush, i_stall,
        output o_if_ready, o_rs1, o_rs2, o_check_regs, o_is_valid,
               o_pipeline_stalled, o_ex_valid, o_ex_pc, o_ex_instr,
               o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_imm
`ifdef ID_STALL_COUNT_EN
               , o_stall_cycles
`endif
    );

    // Environment side (fetch, stall controller, EXE)
    modport master (
        output i_if_valid, i_if_pc, i_if_instr, i_flush, i_stall,
        input  o_if_ready, o_rs1, o_rs2, o_check_regs, o_is_valid,
               o_pipeline_stalled, o_ex_valid, o_ex_pc, o_ex_instr,
               o_ex_rd, o_ex_rs1, o_ex_rs2, o_ex_imm
`ifdef ID_STALL_COUNT_EN
               , o_stall_cycles
`endif
    );

endinterface

// File: rtl/id_stage_decoder.sv
// Purely combinational RV32I field/immediate extraction from the IF/ID word.
module id_stage_decoder
    import id_stage_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [ALEN-1:0] rs1_c,
    output logic [ALEN-1:0] rs2_c,
    output logic [ALEN-1:0] rd_c,
    output check_regs_e     check_regs_c,
    output logic [XLEN-1:0] imm_c
);

    // Source usage, destination and immediate selected by opcode
    always_comb begin
        rs1_c        = ALEN'(instr[19:15]);
        rs2_c        = ALEN'(instr[24:20]);
        rd_c         = ALEN'(instr[11:7]);
        check_regs_c = CHK_NONE;
        imm_c        = '0;
        case (instr[6:0])
            OPC_OP: begin
                check_regs_c = CHK_RS1_RS2;
            end
            OPC_BRANCH: begin
                check_regs_c = CHK_RS1_RS2;
                rd_c         = '0;
                imm_c        = imm_b(instr);
            end
            OPC_STORE: begin
                check_regs_c = CHK_RS1_RS2;
                rd_c         = '0;
                imm_c        = imm_s(instr);
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                check_regs_c = CHK_RS1;
                imm_c        = imm_i(instr);
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_c = imm_u(instr);
            end
            OPC_JAL: begin
                imm_c = imm_j(instr);
            end
            default: begin
                rd_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID register, fetch handshake, stall and
// flush handling, and the ID/EX register. Bubbles always carry rd=0.
// Optional feature macro: ID_STALL_COUNT_EN (saturating o_stall_cycles).
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    id_stage_if.slave   bus
);

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            stalled_q;
    id_ex_t          ex_q;

    logic [ALEN-1:0] dec_rs1;
    logic [ALEN-1:0] dec_rs2;
    logic [ALEN-1:0] dec_rd;
    check_regs_e     dec_chk;
    logic [XLEN-1:0] dec_imm;

    logic            if_ready_c;
    logic            accept_c;

    id_stage_decoder u_decoder (
        .instr        (id_instr),
        .rs1_c        (dec_rs1),
        .rs2_c        (dec_rs2),
        .rd_c         (dec_rd),
        .check_regs_c (dec_chk),
        .imm_c        (dec_imm)
    );

    // A held instruction blocks fetch; a flush drops any same-cycle fetch
    assign if_ready_c = ~id_valid | ~bus.i_stall;
    assign accept_c   = bus.i_if_valid & if_ready_c & ~bus.i_flush;

    // IF/ID register: EMPTY / FULL / HELD tracked by id_valid and i_stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= '0;
        end else if (bus.i_flush) begin
            id_valid <= 1'b0;
        end else if (accept_c) begin
            id_valid <= 1'b1;
            id_pc    <= bus.i_if_pc;
            id_instr <= bus.i_if_instr;
        end else if (!bus.i_stall) begin
            id_valid <= 1'b0;
        end
    end

    // ID/EX register: flush and stall both insert a bubble with rd=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.i_flush || bus.i_stall) begin
            ex_q.valid <= 1'b0;
            ex_q.rd    <= '0;
        end else begin
            ex_q.valid <= id_valid;
            ex_q.pc    <= id_pc;
            ex_q.instr <= id_instr;
            ex_q.rd    <= id_valid ? dec_rd : '0;
            ex_q.rs1   <= dec_rs1;
            ex_q.rs2   <= dec_rs2;
            ex_q.imm   <= dec_imm;
        end
    end

    // Previous-cycle stall seen by the stall controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stalled_q <= 1'b0;
        end else begin
            stalled_q <= bus.i_stall & ~bus.i_flush;
        end
    end

`ifdef ID_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles a live instruction sat stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.i_stall && id_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.o_stall_cycles = stall_cnt;
`endif

    assign bus.o_if_ready         = if_ready_c;
    assign bus.o_rs1              = dec_rs1;
    assign bus.o_rs2              = dec_rs2;
    assign bus.o_check_regs       = id_valid ? dec_chk : CHK_NONE;
    assign bus.o_is_valid         = id_valid;
    assign bus.o_pipeline_stalled = stalled_q;
    assign bus.o_ex_valid         = ex_q.valid;
    assign bus.o_ex_pc            = ex_q.pc;
    assign bus.o_ex_instr         = ex_q.instr;
    assign bus.o_ex_rd            = ex_q.rd;
    assign bus.o_ex_rs1           = ex_q.rs1;
    assign bus.o_ex_rs2           = ex_q.rs2;
    assign bus.o_ex_imm           = ex_q.imm;

endmodule
